// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, default datapath sizing and
// the bit positions of the {C,V,Z,N} status flags.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    localparam int NUM_FLAGS = 4;
    localparam int FLAG_C    = 3;
    localparam int FLAG_V    = 2;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 0;

endpackage

// File: rtl/pipe_addr_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// slave is the adder side, master is the producer/consumer side.
interface pipe_addr_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] num1_IN;
    logic [WIDTH-1:0] num2_IN;
    logic             Carry_IN;
    logic             Sub_IN;
    logic             Valid_IN;
    logic             Ready_OUT;
    logic [WIDTH-1:0] ADDR_OUT;
    logic             Carry_MSB;
    logic             Ovf_OUT;
    logic             Zero_OUT;
    logic             Neg_OUT;
    logic             Valid_OUT;
    logic             Ready_IN;

    modport slave (
        input  num1_IN, num2_IN, Carry_IN, Sub_IN, Valid_IN, Ready_IN,
        output Ready_OUT, ADDR_OUT, Carry_MSB, Ovf_OUT, Zero_OUT, Neg_OUT, Valid_OUT
    );

    modport master (
        output num1_IN, num2_IN, Carry_IN, Sub_IN, Valid_IN, Ready_IN,
        input  Ready_OUT, ADDR_OUT, Carry_MSB, Ovf_OUT, Zero_OUT, Neg_OUT, Valid_OUT
    );

endinterface

// File: rtl/addr_chunk.sv
// Combinational CHUNK-bit ripple adder built from full_addr_1_bit cells.
// Also exposes the carry into the chunk MSB so the top chunk can derive
// signed overflow.
module addr_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = c_in;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : bit_g
        full_addr_1_bit u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .c_in (carry[gi]),
            .sum  (sum[gi]),
            .c_out(carry[gi+1])
        );
    end

    assign c_out = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/full_addr_1_bit.sv
// Single-bit full adder cell.
module full_addr_1_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/pipe_addr.sv
// Pipelined adder/subtractor: one CHUNK-bit ripple slice per stage, carry
// registered between stages, global advance enable for backpressure.
// WIDTH must be a multiple of CHUNK.
module pipe_addr
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    pipe_addr_if.slave bus
);

    localparam int STAGES = WIDTH / CHUNK;

    logic                 adv;
    logic                 ready_out;
    logic                 valid_out;
    logic [WIDTH-1:0]     b_eff;
    logic                 c_eff;
    logic [NUM_FLAGS-1:0] flags_next;
    logic [NUM_FLAGS-1:0] flags_reg;

    // Fold subtraction into addition: invert operand B and the carry-in.
    always_comb begin
        b_eff = bus.num2_IN;
        c_eff = bus.Carry_IN;
        case (bus.Sub_IN)
            OP_ADD: begin
                b_eff = bus.num2_IN;
                c_eff = bus.Carry_IN;
            end
            OP_SUB: begin
                b_eff = ~bus.num2_IN;
                c_eff = ~bus.Carry_IN;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : stage_g
        localparam int SUM_W = (gi + 1) * CHUNK;

        logic [CHUNK-1:0] a_chunk;
        logic [CHUNK-1:0] b_chunk;
        logic [CHUNK-1:0] s_chunk;
        logic             c_in;
        logic             c_out;
        logic             c_msb;
        logic             v_in;
        logic [SUM_W-1:0] sum_next;
        logic [SUM_W-1:0] sum_reg;
        logic             valid_reg;

        // Stage 0 reads the live operands; later stages read the leftovers
        // of the previous stage. Low result chunks accumulate in sum_reg.
        if (gi == 0) begin : g_src
            assign a_chunk  = bus.num1_IN[CHUNK-1:0];
            assign b_chunk  = b_eff[CHUNK-1:0];
            assign c_in     = c_eff;
            assign v_in     = bus.Valid_IN & ready_out;
            assign sum_next = s_chunk;
        end else begin : g_src
            assign a_chunk  = stage_g[gi-1].g_fwd.a_rem_reg[CHUNK-1:0];
            assign b_chunk  = stage_g[gi-1].g_fwd.b_rem_reg[CHUNK-1:0];
            assign c_in     = stage_g[gi-1].g_fwd.carry_reg;
            assign v_in     = stage_g[gi-1].valid_reg;
            assign sum_next = {s_chunk, stage_g[gi-1].sum_reg};
        end

        addr_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (a_chunk),
            .b    (b_chunk),
            .c_in (c_in),
            .sum  (s_chunk),
            .c_out(c_out),
            .c_msb(c_msb)
        );

        // Partial sum and valid bit advance together; frozen on stall.
        always_ff @(posedge CLK_IN) begin
            if (RST_IN) begin
                sum_reg   <= '0;
                valid_reg <= 1'b0;
            end else if (adv) begin
                sum_reg   <= sum_next;
                valid_reg <= v_in;
            end
        end

        // Every stage but the last forwards the carry and the operand chunks
        // still to be added, shifted down so the next chunk sits at bit 0.
        if (gi < STAGES - 1) begin : g_fwd
            localparam int REM_W = WIDTH - SUM_W;

            logic [REM_W-1:0] a_rem_next;
            logic [REM_W-1:0] b_rem_next;
            logic [REM_W-1:0] a_rem_reg;
            logic [REM_W-1:0] b_rem_reg;
            logic             carry_reg;
            logic             c_msb_unused;

            // Only the top chunk's MSB carry matters, for overflow.
            assign c_msb_unused = c_msb;

            if (gi == 0) begin : g_rem_src
                assign a_rem_next = bus.num1_IN[WIDTH-1:CHUNK];
                assign b_rem_next = b_eff[WIDTH-1:CHUNK];
            end else begin : g_rem_src
                assign a_rem_next = stage_g[gi-1].g_fwd.a_rem_reg[REM_W+CHUNK-1:CHUNK];
                assign b_rem_next = stage_g[gi-1].g_fwd.b_rem_reg[REM_W+CHUNK-1:CHUNK];
            end

            // Inter-stage carry and pending operand chunks.
            always_ff @(posedge CLK_IN) begin
                if (RST_IN) begin
                    a_rem_reg <= '0;
                    b_rem_reg <= '0;
                    carry_reg <= 1'b0;
                end else if (adv) begin
                    a_rem_reg <= a_rem_next;
                    b_rem_reg <= b_rem_next;
                    carry_reg <= c_out;
                end
            end
        end
    end

    assign valid_out = stage_g[STAGES-1].valid_reg;
    assign adv       = ~valid_out | bus.Ready_IN;
    assign ready_out = adv & ~RST_IN;

    // Status flags derived from the completed top chunk.
    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_C] = stage_g[STAGES-1].c_out;
        flags_next[FLAG_V] = stage_g[STAGES-1].c_msb ^ stage_g[STAGES-1].c_out;
        flags_next[FLAG_Z] = (stage_g[STAGES-1].sum_next == '0);
        flags_next[FLAG_N] = stage_g[STAGES-1].sum_next[WIDTH-1];
    end

    // Flags register alongside the final stage; reset reports a zero result.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            flags_reg         <= '0;
            flags_reg[FLAG_Z] <= 1'b1;
        end else if (adv) begin
            flags_reg <= flags_next;
        end
    end

    assign bus.Ready_OUT = ready_out;
    assign bus.Valid_OUT = valid_out;
    assign bus.ADDR_OUT  = stage_g[STAGES-1].sum_reg;
    assign bus.Carry_MSB = flags_reg[FLAG_C];
    assign bus.Ovf_OUT   = flags_reg[FLAG_V];
    assign bus.Zero_OUT  = flags_reg[FLAG_Z];
    assign bus.Neg_OUT   = flags_reg[FLAG_N];

endmodule

// File: tb/tb_pipe_addr.sv
// Directed bench for pipe_addr (WIDTH=16, CHUNK=4, latency 4).
module tb_pipe_addr;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int LAT   = WIDTH / CHUNK;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [7];

    pipe_addr_if #(.WIDTH(WIDTH)) bus_if ();

    pipe_addr #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .CLK_IN(clk),
        .RST_IN(rst),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic sub, input logic valid);
        bus_if.num1_IN  = a;
        bus_if.num2_IN  = b;
        bus_if.Carry_IN = cin;
        bus_if.Sub_IN   = sub;
        bus_if.Valid_IN = valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.Ready_IN = 1'b1;
        drive_op(16'h0, 16'h0, 1'b0, OP_ADD, 1'b0);
        @(negedge clk);
        checks++;
        if (bus_if.Ready_OUT !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %0b expected 0", bus_if.Ready_OUT);
        end
        @(negedge clk);
        checks++;
        if ({bus_if.Valid_OUT, bus_if.ADDR_OUT, bus_if.Carry_MSB, bus_if.Ovf_OUT,
             bus_if.Zero_OUT, bus_if.Neg_OUT} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got V=%0b R=%h C=%0b O=%0b Z=%0b N=%0b expected V=0 R=0000 C=0 O=0 Z=1 N=0",
                     bus_if.Valid_OUT, bus_if.ADDR_OUT, bus_if.Carry_MSB, bus_if.Ovf_OUT,
                     bus_if.Zero_OUT, bus_if.Neg_OUT);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.Ready_OUT !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %0b expected 1", bus_if.Ready_OUT);
        end
    endtask

    task automatic test_single_ops();
        int lat;
        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h0010, 16'h0001, 1'b1, OP_SUB, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b1, OP_ADD, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        bus_if.Ready_IN = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1);
            @(negedge clk);
            bus_if.Valid_IN = 1'b0;
            lat = 1;
            while (bus_if.Valid_OUT !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != LAT) begin
                failures++;
                $display("FAIL single_latency[%0d]: got %0d cycles expected %0d", i, lat, LAT);
            end
            checks++;
            if ({bus_if.ADDR_OUT, bus_if.Carry_MSB, bus_if.Ovf_OUT, bus_if.Zero_OUT, bus_if.Neg_OUT}
                !== {vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n}) begin
                failures++;
                $display("FAIL single_result[%0d]: got R=%h C=%0b V=%0b Z=%0b N=%0b expected R=%h C=%0b V=%0b Z=%0b N=%0b",
                         i, bus_if.ADDR_OUT, bus_if.Carry_MSB, bus_if.Ovf_OUT, bus_if.Zero_OUT,
                         bus_if.Neg_OUT, vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n);
            end
            $display("single op %0d: a=%h b=%h cin=%0b sub=%0b -> %h", i, vecs[i].a, vecs[i].b,
                     vecs[i].cin, vecs[i].sub, bus_if.ADDR_OUT);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_res [4];
        logic [15:0] opa;
        logic        exp_valid;
        exp_res = '{16'h0001, 16'h1112, 16'h2223, 16'h3334};
        bus_if.Ready_IN = 1'b1;
        for (int t = 0; t <= 8; t++) begin
            @(negedge clk);
            exp_valid = (t >= 4 && t < 8);
            checks++;
            if (bus_if.Valid_OUT !== exp_valid) begin
                failures++;
                $display("FAIL b2b_valid[t=%0d]: got %0b expected %0b", t, bus_if.Valid_OUT, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (bus_if.ADDR_OUT !== exp_res[t-4]) begin
                    failures++;
                    $display("FAIL b2b_result[%0d]: got %h expected %h", t - 4, bus_if.ADDR_OUT, exp_res[t-4]);
                end
                $display("b2b result %0d: %h", t - 4, bus_if.ADDR_OUT);
            end
            checks++;
            if (bus_if.Ready_OUT !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[t=%0d]: got %0b expected 1", t, bus_if.Ready_OUT);
            end
            opa = 16'(t) * 16'h1111;
            drive_op(opa, 16'h0001, 1'b0, OP_ADD, t < 4);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  pat;
        logic        stall;
        logic [15:0] held;
        logic        exp_ready;
        int          in_idx;
        int          out_idx;
        int          cyc;
        pat = 4'b1001;
        stall = 1'b0;
        held = 16'h0;
        in_idx = 0;
        out_idx = 0;
        cyc = 0;
        while (out_idx < 8 && cyc < 200) begin
            @(negedge clk);
            if (stall) begin
                checks++;
                if ({bus_if.Valid_OUT, bus_if.ADDR_OUT} !== {1'b1, held}) begin
                    failures++;
                    $display("FAIL bp_stable[cyc=%0d]: got V=%0b R=%h expected V=1 R=%h",
                             cyc, bus_if.Valid_OUT, bus_if.ADDR_OUT, held);
                end
            end
            bus_if.Ready_IN = pat[cyc % 4];
            drive_op(in_idx[15:0], 16'h0100, 1'b0, OP_ADD, in_idx < 8);
            #1;
            exp_ready = ~(bus_if.Valid_OUT & ~bus_if.Ready_IN);
            checks++;
            if (bus_if.Ready_OUT !== exp_ready) begin
                failures++;
                $display("FAIL bp_ready[cyc=%0d]: got %0b expected %0b", cyc, bus_if.Ready_OUT, exp_ready);
            end
            if (bus_if.Valid_OUT && bus_if.Ready_IN) begin
                checks++;
                if (bus_if.ADDR_OUT !== 16'h0100 + out_idx[15:0]) begin
                    failures++;
                    $display("FAIL bp_result[%0d]: got %h expected %h", out_idx, bus_if.ADDR_OUT,
                             16'h0100 + out_idx[15:0]);
                end
                $display("bp result %0d: %h at cycle %0d", out_idx, bus_if.ADDR_OUT, cyc);
                out_idx++;
            end
            if (bus_if.Valid_IN && bus_if.Ready_OUT) in_idx++;
            stall = bus_if.Valid_OUT & ~bus_if.Ready_IN;
            held = bus_if.ADDR_OUT;
            cyc++;
        end
        checks++;
        if (out_idx != 8) begin
            failures++;
            $display("FAIL bp_count: got %0d results expected 8", out_idx);
        end
        bus_if.Valid_IN = 1'b0;
        bus_if.Ready_IN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus_if.Valid_OUT !== 1'b0) begin
                failures++;
                $display("FAIL bp_extra[%0d]: got Valid_OUT=%0b R=%h expected 0", i, bus_if.Valid_OUT, bus_if.ADDR_OUT);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        bus_if.Ready_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_op(16'h0011, 16'h0022, 1'b0, OP_ADD, 1'b1);
        end
        @(negedge clk);
        bus_if.Valid_IN = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.Ready_OUT !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ready: got %0b expected 0", bus_if.Ready_OUT);
        end
        @(negedge clk);
        checks++;
        if ({bus_if.Valid_OUT, bus_if.ADDR_OUT, bus_if.Zero_OUT} !== {1'b0, 16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid_state: got V=%0b R=%h Z=%0b expected V=0 R=0000 Z=1",
                     bus_if.Valid_OUT, bus_if.ADDR_OUT, bus_if.Zero_OUT);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus_if.Valid_OUT !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_stale[%0d]: got Valid_OUT=%0b R=%h expected 0", i, bus_if.Valid_OUT, bus_if.ADDR_OUT);
            end
        end
        drive_op(16'h0002, 16'h0003, 1'b0, OP_ADD, 1'b1);
        @(negedge clk);
        bus_if.Valid_IN = 1'b0;
        lat = 1;
        while (bus_if.Valid_OUT !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != LAT) begin
            failures++;
            $display("FAIL rst_mid_latency: got %0d cycles expected %0d", lat, LAT);
        end
        checks++;
        if (bus_if.ADDR_OUT !== 16'h0005) begin
            failures++;
            $display("FAIL rst_mid_result: got %h expected 0005", bus_if.ADDR_OUT);
        end
        $display("post-reset op: 0002+0003 -> %h", bus_if.ADDR_OUT);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_addr.md
Name: pipe_addr

Overview:
- Parametrised, pipelined adder/subtractor; successor to the 4-bit ripple-carry adder.
- A WIDTH-bit operation is split into CHUNK-bit ripple slices, one slice per pipeline stage. The carry is registered between stages.
- Valid/ready handshake on input and output, with backpressure.
- Produces sum plus carry, overflow, zero and negative flags. Feeds the ALU result mux.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; WIDTH/CHUNK = STAGES (derived localparam, ≥1).

Ports:
- CLK_IN  input  1  clock; all state updates on rising edge.
- RST_IN  input  1  synchronous, active-high reset.
- num1_IN  input  WIDTH  operand A.
- num2_IN  input  WIDTH  operand B.
- Carry_IN  input  1  carry-in (add) / borrow-in (sub).
- Sub_IN  input  1  0 = add, 1 = subtract.
- Valid_IN  input  1  operands valid this cycle.
- Ready_OUT  output  1  block accepts operands this cycle.
- ADDR_OUT  output  WIDTH  result.
- Carry_MSB  output  1  carry out of the MSB.
- Ovf_OUT  output  1  signed overflow.
- Zero_OUT  output  1  ADDR_OUT == 0.
- Neg_OUT  output  1  ADDR_OUT[WIDTH-1].
- Valid_OUT  output  1  result valid.
- Ready_IN  input  1  downstream accepts result.

Behaviour:
- Arithmetic:
  - Add: A + B + Carry_IN.
  - Sub: A + ~B + ~Carry_IN, i.e. A − B − Carry_IN.
  - Carry_MSB is the raw carry-out, so for sub 1 = no borrow.
  - Ovf_OUT = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Pipeline: STAGES stages with a global advance enable: adv = ~Valid_OUT | Ready_IN.
  - Ready_OUT = adv, combinational, no registered path from Valid_IN.
- Acceptance: a transfer occurs when Valid_IN & Ready_OUT.
  - Stage 0 captures A, the B/Sub-adjusted operand, and the effective carry.
  - It computes chunk 0 and registers the chunk-0 sum, the carry out, and the remaining operand chunks.
- Stage k (1..STAGES-1): on adv, adds chunk k using the registered carry from stage k-1.
  - Already-computed low chunks shift forward unchanged.
  - Unused high operand chunks shift forward unchanged.
- Final stage registers all outputs, including the flags.
- Latency: exactly STAGES cycles from acceptance to Valid_OUT when Ready_IN is held high.
- Throughput: 1 op/cycle with no bubbles inserted.
- Stage valid bits:
  - On adv, each valid bit shifts forward; the stage-0 valid loads Valid_IN & Ready_OUT.
  - When adv=0, all stages hold: data, flags and valids frozen.
  - ADDR_OUT and the flags stay stable while Valid_OUT & ~Ready_IN.
- Bubbles: when Valid_OUT=0, adv=1, so bubbles compress out of the pipeline.
- STAGES=1: single registered ripple adder, latency 1.
- Reset (RST_IN=1 at an edge):
  - All valid bits cleared; Valid_OUT=0 next cycle.
  - ADDR_OUT=0, Carry_MSB=0, Ovf_OUT=0, Neg_OUT=0, Zero_OUT=1 next cycle.
  - In-flight operations are discarded and never emerge.
  - Ready_OUT=0 while RST_IN is high.
- Simultaneous output pop and input push in the same cycle: both occur and the pipeline shifts.
- Operand width: the WIDTH-bit result wraps modulo 2^WIDTH; the extra bit goes only to Carry_MSB.

Decomposition:
- Shared package alu_pkg:
  - ALU op encoding constants (OP_ADD=1'b0, OP_SUB=1'b1).
  - Default WIDTH/CHUNK constants.
  - Flag bit-index constants {C,V,Z,N} for the ALU status register.
- Sub-module addr_chunk, instantiated once per stage:
  - Combinational CHUNK-bit ripple of full_addr_1_bit cells.
  - Parameter CHUNK.
  - Outputs the sum, carry out, and carry into the chunk MSB (used for overflow).

Test Plan (WIDTH=16, CHUNK=4, latency 4):
- Add 0x7FFF+0x0001, Carry_IN=0, Ready_IN=1 → 4 cycles later ADDR_OUT=0x8000, C=0, V=1, N=1, Z=0.
- Add 0xFFFF+0x0001, Carry_IN=0 → ADDR_OUT=0x0000, C=1, V=0, Z=1, N=0.
- Sub 0x0005−0x0007, Carry_IN=0 → 0xFFFE, C=0, V=0, N=1.
- Sub 0x8000−0x0001, Carry_IN=0 → 0x7FFF, C=1, V=1.
- Sub 0x0010−0x0001, Carry_IN=1 → 0x000E, C=1.
- Backpressure: stream 8 adds (i+0x0100, i=0..7) while Ready_IN toggles 1,0,0,1,… → exactly 8 results, in order, values 0x0100..0x0107.
  - Outputs are stable while stalled.
  - Ready_OUT=0 whenever Valid_OUT & ~Ready_IN.
- Reset mid-flight: accept 3 ops, assert RST_IN for 1 cycle.
  - Next cycle: Valid_OUT=0, ADDR_OUT=0, Zero_OUT=1.
  - No stale results appear in the 6 cycles after release.
  - A new op 0x0002+0x0003 returns 0x0005 after 4 cycles.
